// File: rtl/seq_detect_mealy_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlap and
// non-overlap modes, a modulo-HIT_LIMIT hit counter and a wrap pulse.
// A match is decided combinationally on the incoming bit (Mealy).
// It is reported on dout one cycle later.
module seq_detect_mealy_param #(
  parameter int unsigned             PATTERN_W   = 5,
  parameter logic [PATTERN_W-1:0]    PATTERN_RST = 5'b10110,
  parameter int unsigned             COUNT_W     = 4,
  parameter int unsigned             HIT_LIMIT   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic                 overlap_en,
  input  logic                 pat_load,
  input  logic [PATTERN_W-1:0] pat_in,
  input  logic                 clr_count,
  output logic                 dout,
  output logic [COUNT_W-1:0]   hit_count,
  output logic                 limit_pulse
);

  localparam int unsigned FILL_W = $clog2(PATTERN_W + 1);

  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 dout_q, dout_d;
  logic                 lim_q, lim_d;

  logic [PATTERN_W-1:0] shifted;
  logic                 accept;
  logic                 match;

  // A bit that arrives together with a pattern load is discarded.
  assign shifted = {hist_q[PATTERN_W-2:0], din};
  assign accept  = din_valid && !pat_load;
  assign match   = accept && (shifted == pattern_q) &&
                   (fill_q >= FILL_W'(PATTERN_W - 1));

  // Next-state logic for the pattern, the history, the fill level and the hit counter.
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    dout_d    = 1'b0;
    lim_d     = 1'b0;

    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      if (match && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shifted;
        if (fill_q != FILL_W'(PATTERN_W))
          fill_d = fill_q + FILL_W'(1);
      end
    end

    dout_d = match;

    if (clr_count) begin
      cnt_d = '0;
    end else if (match) begin
      if (cnt_q == COUNT_W'(HIT_LIMIT - 1)) begin
        cnt_d = '0;
        lim_d = 1'b1;
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  // State registers, with a synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= PATTERN_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      dout_q    <= 1'b0;
      lim_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      lim_q     <= lim_d;
    end
  end

  assign dout        = dout_q;
  assign hit_count   = cnt_q;
  assign limit_pulse = lim_q;

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// Self-checking bench for seq_detect_mealy_param. The directed scenarios and
// the randomized traffic are both checked every cycle against a queue-based
// model of the accepted bit stream.
module tb_seq_detect_mealy_param;

  localparam int unsigned W  = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned HL = 10;
  localparam logic [W-1:0] PRST = 5'b10110;

  logic          clk = 1'b0;
  logic          rst, din, din_valid, overlap_en, pat_load, clr_count;
  logic [W-1:0]  pat_in;
  logic          dout, limit_pulse;
  logic [CW-1:0] hit_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  // Model state: the accepted bits since the last flush, the pattern, and the hit total.
  bit           mq[$];
  logic [W-1:0] m_pat = PRST;
  int           m_cnt = 0;
  logic         e_dout = 1'b0;
  logic         e_lim = 1'b0;

  seq_detect_mealy_param #(
    .PATTERN_W(W), .PATTERN_RST(PRST), .COUNT_W(CW), .HIT_LIMIT(HL)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .clr_count(clr_count), .dout(dout), .hit_count(hit_count),
    .limit_pulse(limit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    bit m;
    if (rst) begin
      mq.delete();
      m_pat  = PRST;
      m_cnt  = 0;
      e_dout = 1'b0;
      e_lim  = 1'b0;
      return;
    end
    m = 1'b0;
    if (pat_load) begin
      m_pat = pat_in;
      mq.delete();
    end else if (din_valid) begin
      mq.push_back(din);
      if (mq.size() >= W) begin
        m = 1'b1;
        for (int i = 0; i < W; i++)
          if (mq[mq.size() - W + i] != m_pat[W-1-i]) m = 1'b0;
      end
      if (m && !overlap_en) mq.delete();
      while (mq.size() > W) void'(mq.pop_front());
    end
    e_dout = m;
    e_lim  = 1'b0;
    if (clr_count) m_cnt = 0;
    else if (m) begin
      m_cnt++;
      if (m_cnt == HL) begin
        m_cnt = 0;
        e_lim = 1'b1;
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input logic d, input logic v, input logic ov,
                      input logic ld, input logic [W-1:0] pin,
                      input logic clr, input logic r);
    din = d; din_valid = v; overlap_en = ov; pat_load = ld;
    pat_in = pin; clr_count = clr; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("dout", int'(dout), int'(e_dout));
    check("hit_count", int'(hit_count), m_cnt);
    check("limit_pulse", int'(limit_pulse), int'(e_lim));
    if (dout) pulses++;
    #4;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input logic ov);
    logic [15:0] b;
    b = bits;
    for (int i = n - 1; i >= 0; i--) step(b[i], 1'b1, ov, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #2;
    // Reset state
    do_reset();
    check("rst_dout", int'(dout), 0);
    check("rst_count", int'(hit_count), 0);
    check("rst_limit", int'(limit_pulse), 0);

    // 1: single match with the default pattern
    pulses = 0;
    feed(16'b10110, 5, 1'b1);
    check("t1_dout", int'(dout), 1);
    check("t1_count", int'(hit_count), 1);

    // 2: overlapping versus non-overlapping matches
    do_reset(); pulses = 0;
    feed(16'b10110110, 8, 1'b1);
    check("t2_overlap_pulses", pulses, 2);
    do_reset(); pulses = 0;
    feed(16'b10110110, 8, 1'b0);
    check("t2_nonoverlap_pulses", pulses, 1);

    // 3: a stall in the middle of the pattern
    do_reset(); pulses = 0;
    feed(16'b101, 3, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("t3_stall_pulses", pulses, 0);
    feed(16'b10, 2, 1'b1);
    check("t3_pulses", pulses, 1);

    // 4: counter wrap after ten matches, then clear on a match cycle
    do_reset(); pulses = 0;
    feed(16'b10110, 5, 1'b1);
    repeat (8) feed(16'b110, 3, 1'b1);
    check("t4_count9", int'(hit_count), 9);
    feed(16'b110, 3, 1'b1);
    check("t4_wrap_count", int'(hit_count), 0);
    check("t4_wrap_pulse", int'(limit_pulse), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("t4_pulse_once", int'(limit_pulse), 0);
    feed(16'b11, 2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("t4_clr_dout", int'(dout), 1);
    check("t4_clr_count", int'(hit_count), 0);

    // 5: load a new pattern in the middle of the stream
    do_reset(); pulses = 0;
    feed(16'b10, 2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'b11100, 1'b0, 1'b0);
    feed(16'b11100, 5, 1'b1);
    check("t5_new_match", pulses, 1);
    feed(16'b10110, 5, 1'b1);
    check("t5_old_nomatch", pulses, 1);

    // 6: reset in the middle of a partial match
    do_reset(); pulses = 0;
    feed(16'b1011, 4, 1'b1);
    do_reset();
    feed(16'b0, 1, 1'b1);
    check("t6_pulses", pulses, 0);
    check("t6_count", int'(hit_count), 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] p;
      p = W'($urandom);
      step(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 99) == 0), p,
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
